chram_writer: RTL and testbench

Text-console writer for the character-map video block. Accepts character, cursor, colour and clear commands over a valid/ready handshake. Translates them into single-cycle writes to the character RAM, foreground-colour RAM and background-colour RAM. It drives the write side of the same `{row[5:0], col[5:0]}` 12-bit address space that the character-map renderer reads.

---
 rtl/chram_writer.sv | 189 ++++++++++++++++++
 tb/tb_chram_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chram_writer.sv
// rtl/chram_writer.sv - text-console command writer for the character-map RAMs
// Turns putc/setpos/setcol/clear commands into single-cycle {char, fg, bg} cell writes.
module chram_writer #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic [11:0] chram_addr,
    output logic        chram_wr,
    output logic [7:0]  chram_data_in,
    output logic [7:0]  fgcolram_data_in,
    output logic [7:0]  bgcolram_data_in,
    output logic [5:0]  cursor_x,
    output logic [5:0]  cursor_y
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLRLINE = 2'd1;
    localparam logic [1:0] S_CLEAR   = 2'd2;

    localparam logic [1:0] OP_PUTC   = 2'b00;
    localparam logic [1:0] OP_SETPOS = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_SETCOL = 2'b11;

    localparam logic [5:0] COL_MAX = 6'(COLS - 1);
    localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
    localparam logic [7:0] BLANK   = 8'h20;
    localparam logic [7:0] NEWLINE = 8'h0A;

    logic [1:0]  state_q, state_d;
    logic [5:0]  sweep_col_q, sweep_col_d;
    logic [5:0]  sweep_row_q, sweep_row_d;
    logic [5:0]  cursor_x_q, cursor_x_d;
    logic [5:0]  cursor_y_q, cursor_y_d;
    logic [7:0]  fg_q, fg_d;
    logic [7:0]  bg_q, bg_d;
    logic [11:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  chr_q, chr_d;
    logic [7:0]  fg_out_q, fg_out_d;
    logic [7:0]  bg_out_q, bg_out_d;

    logic [5:0]  next_row;
    logic [5:0]  pos_col;
    logic [5:0]  pos_row;

    assign cmd_ready = (state_q == S_IDLE) && !reset;

    assign next_row = (cursor_y_q == ROW_MAX) ? 6'd0 : cursor_y_q + 6'd1;
    assign pos_col  = (cmd_data[5:0]  > COL_MAX) ? COL_MAX : cmd_data[5:0];
    assign pos_row  = (cmd_data[13:8] > ROW_MAX) ? ROW_MAX : cmd_data[13:8];

    always_comb begin
        state_d     = state_q;
        sweep_col_d = sweep_col_q;
        sweep_row_d = sweep_row_q;
        cursor_x_d  = cursor_x_q;
        cursor_y_d  = cursor_y_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        addr_d      = addr_q;
        wr_d        = 1'b0;
        chr_d       = chr_q;
        fg_out_d    = fg_out_q;
        bg_out_d    = bg_out_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUTC: begin
                            if (cmd_data[7:0] == NEWLINE) begin
                                cursor_x_d  = 6'd0;
                                cursor_y_d  = next_row;
                                sweep_col_d = 6'd0;
                                state_d     = S_CLRLINE;
                            end else begin
                                wr_d     = 1'b1;
                                addr_d   = {cursor_y_q, cursor_x_q};
                                chr_d    = cmd_data[7:0];
                                fg_out_d = fg_q;
                                bg_out_d = bg_q;
                                if (cursor_x_q == COL_MAX) begin
                                    cursor_x_d  = 6'd0;
                                    cursor_y_d  = next_row;
                                    sweep_col_d = 6'd0;
                                    state_d     = S_CLRLINE;
                                end else begin
                                    cursor_x_d = cursor_x_q + 6'd1;
                                end
                            end
                        end
                        OP_SETPOS: begin
                            cursor_x_d = pos_col;
                            cursor_y_d = pos_row;
                        end
                        OP_CLEAR: begin
                            sweep_col_d = 6'd0;
                            sweep_row_d = 6'd0;
                            state_d     = S_CLEAR;
                        end
                        default: begin
                            fg_d = cmd_data[7:0];
                            bg_d = cmd_data[15:8];
                        end
                    endcase
                end
            end
            S_CLRLINE: begin
                // cursor_y already points at the freshly advanced row
                wr_d     = 1'b1;
                addr_d   = {cursor_y_q, sweep_col_q};
                chr_d    = BLANK;
                fg_out_d = fg_q;
                bg_out_d = bg_q;
                if (sweep_col_q == COL_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    sweep_col_d = sweep_col_q + 6'd1;
                end
            end
            S_CLEAR: begin
                wr_d     = 1'b1;
                addr_d   = {sweep_row_q, sweep_col_q};
                chr_d    = BLANK;
                fg_out_d = fg_q;
                bg_out_d = bg_q;
                if (sweep_col_q == COL_MAX) begin
                    sweep_col_d = 6'd0;
                    if (sweep_row_q == ROW_MAX) begin
                        state_d    = S_IDLE;
                        cursor_x_d = 6'd0;
                        cursor_y_d = 6'd0;
                    end else begin
                        sweep_row_d = sweep_row_q + 6'd1;
                    end
                end else begin
                    sweep_col_d = sweep_col_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sweep_col_q <= 6'd0;
            sweep_row_q <= 6'd0;
            cursor_x_q  <= 6'd0;
            cursor_y_q  <= 6'd0;
            fg_q        <= 8'hFF;
            bg_q        <= 8'h00;
            addr_q      <= 12'd0;
            wr_q        <= 1'b0;
            chr_q       <= 8'd0;
            fg_out_q    <= 8'd0;
            bg_out_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            sweep_col_q <= sweep_col_d;
            sweep_row_q <= sweep_row_d;
            cursor_x_q  <= cursor_x_d;
            cursor_y_q  <= cursor_y_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            chr_q       <= chr_d;
            fg_out_q    <= fg_out_d;
            bg_out_q    <= bg_out_d;
        end
    end

    assign chram_addr       = addr_q;
    assign chram_wr         = wr_q;
    assign chram_data_in    = chr_q;
    assign fgcolram_data_in = fg_out_q;
    assign bgcolram_data_in = bg_out_q;
    assign cursor_x         = cursor_x_q;
    assign cursor_y         = cursor_y_q;

endmodule

// File: tb/tb_chram_writer.sv
// tb/tb_chram_writer.sv - scoreboard bench for chram_writer
// Expected cell writes are queued as commands are driven and popped as the DUT writes.
module tb_chram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [11:0] chram_addr;
    logic        chram_wr;
    logic [7:0]  chram_data_in;
    logic [7:0]  fgcolram_data_in;
    logic [7:0]  bgcolram_data_in;
    logic [5:0]  cursor_x;
    logic [5:0]  cursor_y;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic [35:0] exp_q[$];
    int model_x, model_y;
    logic [7:0] model_fg, model_bg;

    always #5 clk = ~clk;

    chram_writer #(.COLS(40), .ROWS(30)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .chram_addr(chram_addr), .chram_wr(chram_wr),
        .chram_data_in(chram_data_in),
        .fgcolram_data_in(fgcolram_data_in),
        .bgcolram_data_in(bgcolram_data_in),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && chram_wr) begin
            wr_cnt++;
            check("col_in_range", 64'(chram_addr[5:0] < 6'd40), 64'd1);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         chram_addr, chram_data_in);
            end else begin
                check("write", {chram_addr, chram_data_in, fgcolram_data_in, bgcolram_data_in},
                      exp_q.pop_front());
            end
        end
    end

    task automatic push_w(input int row, input int col, input logic [7:0] ch);
        exp_q.push_back({row[5:0], col[5:0], ch, model_fg, model_bg});
    endtask

    task automatic model_row();
        model_x = 0;
        model_y = (model_y == 29) ? 0 : model_y + 1;
        for (int c = 0; c < 40; c++) push_w(model_y, c, 8'h20);
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [15:0] data);
        case (op)
            2'b00: begin
                if (data[7:0] == 8'h0A) model_row();
                else begin
                    push_w(model_y, model_x, data[7:0]);
                    if (model_x == 39) model_row();
                    else model_x++;
                end
            end
            2'b01: begin
                model_x = (int'(data[5:0]) > 39) ? 39 : int'(data[5:0]);
                model_y = (int'(data[13:8]) > 29) ? 29 : int'(data[13:8]);
            end
            2'b10: begin
                for (int r = 0; r < 30; r++)
                    for (int c = 0; c < 40; c++) push_w(r, c, 8'h20);
                model_x = 0;
                model_y = 0;
            end
            default: begin
                model_fg = data[7:0];
                model_bg = data[15:8];
            end
        endcase
    endtask

    // Called in the negedge phase; returns the number of not-ready cycles seen.
    task automatic wait_ready(output int low_cycles);
        low_cycles = 0;
        while (!cmd_ready && low_cycles < 5000) begin
            @(negedge clk);
            #1;
            if (!cmd_ready) low_cycles++;
        end
        if (!cmd_ready) check("ready_timeout", 64'(cmd_ready), 64'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] data);
        int dummy;
        wait_ready(dummy);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        model_cmd(op, data);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic check_cursor(input string tag);
        check(tag, {58'd0, cursor_y, cursor_x} , 64'({model_y[5:0], model_x[5:0]}));
    endtask

    initial begin
        int low;
        int base;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 16'd0;
        model_x   = 0;
        model_y   = 0;
        model_fg  = 8'hFF;
        model_bg  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_outputs", {chram_wr, chram_addr, chram_data_in, fgcolram_data_in,
                              bgcolram_data_in, cursor_x, cursor_y}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // first character lands at the origin with reset colours
        send(2'b00, 16'h0041);
        check("putc_wr", 64'(chram_wr), 64'd1);
        check("putc_addr", 64'(chram_addr), 64'h000);
        check_cursor("putc_cursor");

        // back-to-back characters: one write per cycle
        send(2'b00, 16'h0061);
        send(2'b00, 16'h0062);
        check_cursor("b2b_cursor");

        // wrap at the last column blanks the next row
        send(2'b11, 16'hC007);
        send(2'b01, 16'h0527);
        check_cursor("setpos_cursor");
        send(2'b00, 16'h0042);
        check("wrap_addr", 64'(chram_addr), 64'h167);
        check("wrap_fg", 64'(fgcolram_data_in), 64'h07);
        check_cursor("wrap_cursor");
        wait_ready(low);
        check("wrap_ready_low", 64'(low + 1), 64'd40);

        // newline on the last row wraps to row 0 with no character write
        send(2'b01, 16'h1D00);
        base = wr_cnt;
        send(2'b00, 16'h000A);
        check("nl_no_char_wr", 64'(chram_wr), 64'd0);
        check_cursor("nl_cursor");
        wait_ready(low);
        check("nl_writes", 64'(wr_cnt - base), 64'd40);

        // full-screen clear
        base = wr_cnt;
        send(2'b10, 16'h0000);
        wait_ready(low);
        check("clr_writes", 64'(wr_cnt - base), 64'd1200);
        check("clr_ready_low", 64'(low + 1), 64'd1200);
        check_cursor("clr_cursor");

        // clamping
        send(2'b01, 16'h3F3F);
        check("clamp_cursor", {58'd0, cursor_y, cursor_x}, 64'({6'd29, 6'd39}));

        // reset mid-clear aborts the sweep
        base = wr_cnt;
        send(2'b10, 16'h0000);
        low = 0;
        while ((wr_cnt - base) < 100 && low < 2000) begin
            @(negedge clk);
            #1;
            low++;
        end
        check("abort_reached_100", 64'(wr_cnt - base), 64'd100);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 16'h0055;
        @(negedge clk);
        #1;
        check("abort_wr_low", 64'(chram_wr), 64'd0);
        check("abort_ready_low", 64'(cmd_ready), 64'd0);
        exp_q.delete();
        model_x  = 0;
        model_y  = 0;
        model_fg = 8'hFF;
        model_bg = 8'h00;
        cmd_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_ready", 64'(cmd_ready), 64'd1);
        check_cursor("post_rst_cursor");
        base = wr_cnt;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 64'(wr_cnt - base), 64'd0);

        // post-reset colours are back to defaults
        send(2'b00, 16'h0043);
        check("post_rst_fg", 64'(fgcolram_data_in), 64'hFF);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
